// File: rtl/pfc_vec.sv
// Program flow controller with vectored, nested, prioritised interrupts.
// Each cycle the next PC is one of four sources, in this priority order:
//   stall hold > interrupt take > iret > increment / jump.
// A small stack records {return address, channel} for each nesting level.
module pfc_vec #(
  parameter int unsigned       WIDTH      = 16,
  parameter int unsigned       NINTR      = 4,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [WIDTH-1:0]  VEC_BASE   = WIDTH'(16'h0010),
  parameter int unsigned       VEC_STRIDE = 4
) (
  input  logic                         clk_pc,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic [WIDTH-1:0]             cond,
  input  logic [WIDTH-1:0]             alu,
  input  logic                         pfc_ctrl,
  input  logic                         iret,
  input  logic [NINTR-1:0]             intr,
  input  logic                         intr_en,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_inc,
  output logic [WIDTH-1:0]             intr_ra,
  output logic [NINTR-1:0]             intr_ack,
  output logic [$clog2(DEPTH+1)-1:0]   nest_level,
  output logic                         iret_err
);

  localparam int unsigned     LW      = $clog2(DEPTH + 1);
  localparam int unsigned     CW      = (NINTR > 1) ? $clog2(NINTR) : 1;
  localparam logic [LW-1:0]   DepthL  = LW'(DEPTH);
  localparam logic [LW-1:0]   OneL    = LW'(1);

  // State
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [LW-1:0]    nest_q, nest_d;
  logic             err_q, err_d;
  logic [NINTR-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] ra_q [DEPTH];
  logic [WIDTH-1:0] ra_d [DEPTH];
  logic [CW-1:0]    ch_q [DEPTH];
  logic [CW-1:0]    ch_d [DEPTH];

  // Decoded control
  logic [WIDTH-1:0] inc_pc;
  logic [WIDTH-1:0] np;
  logic [WIDTH-1:0] vec_pc;
  logic [CW-1:0]    req_k;
  logic             req_any;
  logic [WIDTH-1:0] top_ra;
  logic [CW-1:0]    top_ch;
  logic [CW-1:0]    below_ch;
  logic             elig_top;
  logic             elig_below;
  logic             take_new;
  logic             tail;
  logic             pop;
  logic             err_set;

  // Lowest asserted request index wins (channel 0 is highest priority)
  always_comb begin
    req_k = '0;
    for (int i = int'(NINTR) - 1; i >= 0; i--) begin
      if (intr[i]) begin
        req_k = CW'(i);
      end
    end
  end

  // Peek at the top entry and the one beneath it
  always_comb begin
    top_ra   = '0;
    top_ch   = '0;
    below_ch = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (int'(nest_q) == i + 1) begin
        top_ra = ra_q[i];
        top_ch = ch_q[i];
      end
      if (int'(nest_q) == i + 2) begin
        below_ch = ch_q[i];
      end
    end
  end

  // Next-PC candidates and take/return decisions
  always_comb begin
    inc_pc  = pc_q + WIDTH'(1);
    np      = (pfc_ctrl && (cond != '0)) ? alu : inc_pc;
    vec_pc  = VEC_BASE + WIDTH'(req_k) * WIDTH'(VEC_STRIDE);
    req_any = intr_en && (intr != '0);

    // Only a strictly higher-priority channel may preempt the active one
    elig_top   = req_any && ((nest_q == '0) || (req_k < top_ch));
    // On iret the active handler is leaving, so compare with its parent
    elig_below = req_any && ((nest_q <= OneL) || (req_k < below_ch));

    // iret with a live stack is resolved entirely by tail / pop
    take_new = !stall && elig_top && (nest_q < DepthL) && !(iret && (nest_q != '0));
    tail     = !stall && iret && (nest_q != '0) && elig_below;
    pop      = !stall && iret && (nest_q != '0) && !elig_below;
    err_set  = !stall && iret && (nest_q == '0) && !take_new;
  end

  // Next-state for PC, stack, occupancy, error flag and acknowledge
  always_comb begin
    pc_d   = pc_q;
    nest_d = nest_q;
    err_d  = err_q;
    ack_d  = '0;
    ra_d   = ra_q;
    ch_d   = ch_q;

    if (stall) begin
      pc_d = pc_q;
    end else if (take_new) begin
      pc_d   = vec_pc;
      nest_d = nest_q + OneL;
      ack_d  = NINTR'(1) << req_k;
    end else if (tail) begin
      pc_d  = vec_pc;
      ack_d = NINTR'(1) << req_k;
    end else if (pop) begin
      pc_d   = top_ra;
      nest_d = nest_q - OneL;
    end else if (err_set) begin
      pc_d  = inc_pc;
      err_d = 1'b1;
    end else begin
      pc_d = np;
    end

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (take_new && (int'(nest_q) == i)) begin
        ra_d[i] = np;
        ch_d[i] = req_k;
      end
      // Tail-chain reuses the slot: parent's return address, new channel
      if (tail && (int'(nest_q) == i + 1)) begin
        ra_d[i] = top_ra;
        ch_d[i] = req_k;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_pc or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      nest_q <= '0;
      err_q  <= 1'b0;
      ack_q  <= '0;
      ra_q   <= '{default: '0};
      ch_q   <= '{default: '0};
    end else begin
      pc_q   <= pc_d;
      nest_q <= nest_d;
      err_q  <= err_d;
      ack_q  <= ack_d;
      ra_q   <= ra_d;
      ch_q   <= ch_d;
    end
  end

  // Outputs
  always_comb begin
    pc         = pc_q;
    pc_inc     = inc_pc;
    intr_ra    = top_ra;
    intr_ack   = stall ? '0 : ack_q;
    nest_level = nest_q;
    iret_err   = err_q;
  end

endmodule

// File: tb/tb_pfc_vec.sv
// Directed vector bench for pfc_vec (DEPTH=2 so the stack-full case is reachable).
module tb_pfc_vec;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int LW = $clog2(D + 1);

  logic          clk_pc = 1'b0;
  logic          rst_n;
  logic          stall;
  logic [W-1:0]  cond;
  logic [W-1:0]  alu;
  logic          pfc_ctrl;
  logic          iret;
  logic [N-1:0]  intr;
  logic          intr_en;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc_inc;
  logic [W-1:0]  intr_ra;
  logic [N-1:0]  intr_ack;
  logic [LW-1:0] nest_level;
  logic          iret_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          stall;
    logic [W-1:0]  cond;
    logic [W-1:0]  alu;
    logic          pfc;
    logic          iret;
    logic [N-1:0]  intr;
    logic          en;
    logic [W-1:0]  x_pc;
    logic [N-1:0]  x_ack;
    int            x_nest;
    logic [W-1:0]  x_ra;
    logic          x_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk_pc = ~clk_pc;

  pfc_vec #(
    .WIDTH      (W),
    .NINTR      (N),
    .DEPTH      (D),
    .RESET_PC   (16'h0000),
    .VEC_BASE   (16'h0010),
    .VEC_STRIDE (4)
  ) dut (
    .clk_pc     (clk_pc),
    .rst_n      (rst_n),
    .stall      (stall),
    .cond       (cond),
    .alu        (alu),
    .pfc_ctrl   (pfc_ctrl),
    .iret       (iret),
    .intr       (intr),
    .intr_en    (intr_en),
    .pc         (pc),
    .pc_inc     (pc_inc),
    .intr_ra    (intr_ra),
    .intr_ack   (intr_ack),
    .nest_level (nest_level),
    .iret_err   (iret_err)
  );

  task automatic add(input logic s, input logic [W-1:0] c, input logic [W-1:0] a,
                     input logic p, input logic r, input logic [N-1:0] i, input logic e,
                     input logic [W-1:0] xp, input logic [N-1:0] xa, input int xn,
                     input logic [W-1:0] xr, input logic xe);
    vec_t v;
    v.stall = s;  v.cond = c;   v.alu = a;    v.pfc = p;    v.iret = r;
    v.intr = i;   v.en = e;     v.x_pc = xp;  v.x_ack = xa; v.x_nest = xn;
    v.x_ra = xr;  v.x_err = xe;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] xp, input logic [N-1:0] xa,
                       input int xn, input logic [W-1:0] xr, input logic xe);
    logic [W-1:0] xinc;
    xinc = xp + 16'd1;
    n_tests++;
    if (pc !== xp || pc_inc !== xinc || intr_ack !== xa || nest_level !== LW'(xn) ||
        intr_ra !== xr || iret_err !== xe) begin
      n_fail++;
      $display("FAIL %s: got pc=%h pc_inc=%h ack=%b nest=%0d ra=%h err=%b; want pc=%h pc_inc=%h ack=%b nest=%0d ra=%h err=%b",
               name, pc, pc_inc, intr_ack, nest_level, intr_ra, iret_err,
               xp, xinc, xa, xn, xr, xe);
    end
  endtask

  task automatic drive_idle();
    stall = 1'b0; cond = '0; alu = '0; pfc_ctrl = 1'b0; iret = 1'b0;
    intr = '0; intr_en = 1'b1;
  endtask

  initial begin
    // stall cond alu pfc iret intr en | pc ack nest ra err
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 4'b0000, 1, W'(i + 1), 0, 0, 0, 0);
    add(0, 16'd1, 16'h1234, 1, 0, 4'b0000, 1, 16'h1234, 4'b0000, 0, 16'h0000, 0); // 6 jump
    add(0, 16'd0, 16'h1234, 1, 0, 4'b0000, 1, 16'h1235, 4'b0000, 0, 16'h0000, 0); // 7 no jump
    add(0, 16'd7, 16'h0005, 1, 0, 4'b0000, 1, 16'h0005, 4'b0000, 0, 16'h0000, 0); // 8
    add(0, 0, 0, 0, 0, 4'b0100, 1, 16'h0018, 4'b0100, 1, 16'h0006, 0); // 9  take ch2
    add(0, 0, 0, 0, 0, 4'b0000, 1, 16'h0019, 4'b0000, 1, 16'h0006, 0); // 10
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h0006, 4'b0000, 0, 16'h0000, 0); // 11 iret
    add(0, 0, 0, 0, 0, 4'b0100, 1, 16'h0018, 4'b0100, 1, 16'h0007, 0); // 12 take ch2
    add(0, 0, 0, 0, 0, 4'b1000, 1, 16'h0019, 4'b0000, 1, 16'h0007, 0); // 13 ch3 ignored
    add(0, 0, 0, 0, 0, 4'b0001, 1, 16'h0010, 4'b0001, 2, 16'h001A, 0); // 14 nest ch0
    add(0, 0, 0, 0, 0, 4'b0000, 1, 16'h0011, 4'b0000, 2, 16'h001A, 0); // 15
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h001A, 4'b0000, 1, 16'h0007, 0); // 16 iret
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h0007, 4'b0000, 0, 16'h0000, 0); // 17 iret
    add(0, 0, 0, 0, 0, 4'b0100, 1, 16'h0018, 4'b0100, 1, 16'h0008, 0); // 18 take ch2
    add(0, 0, 0, 0, 0, 4'b0010, 1, 16'h0014, 4'b0010, 2, 16'h0019, 0); // 19 nest ch1
    add(0, 0, 0, 0, 0, 4'b0001, 1, 16'h0015, 4'b0000, 2, 16'h0019, 0); // 20 full
    add(0, 0, 0, 0, 0, 4'b0001, 1, 16'h0016, 4'b0000, 2, 16'h0019, 0); // 21 full
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h0019, 4'b0000, 1, 16'h0008, 0); // 22 iret
    add(0, 0, 0, 0, 0, 4'b0001, 1, 16'h0010, 4'b0001, 2, 16'h001A, 0); // 23 now taken
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h001A, 4'b0000, 1, 16'h0008, 0); // 24
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h0008, 4'b0000, 0, 16'h0000, 0); // 25
    add(0, 16'd1, 16'h0100, 1, 0, 4'b0100, 1, 16'h0018, 4'b0100, 1, 16'h0100, 0); // 26 jump+take
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h0100, 4'b0000, 0, 16'h0000, 0); // 27
    add(0, 0, 0, 0, 1, 4'b0000, 1, 16'h0101, 4'b0000, 0, 16'h0000, 1); // 28 iret empty
    add(0, 16'd1, 16'hFFFF, 1, 0, 4'b0000, 1, 16'hFFFF, 4'b0000, 0, 16'h0000, 1); // 29
    add(0, 0, 0, 0, 0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 16'h0000, 1); // 30 wrap
    add(0, 0, 0, 0, 0, 4'b0100, 1, 16'h0018, 4'b0100, 1, 16'h0001, 1); // 31 take ch2
    add(0, 0, 0, 0, 0, 4'b0000, 1, 16'h0019, 4'b0000, 1, 16'h0001, 1); // 32
    add(0, 0, 0, 0, 1, 4'b0010, 1, 16'h0014, 4'b0010, 1, 16'h0001, 1); // 33 tail-chain
    for (int i = 0; i < 3; i++)                                         // 34-36 stall
      add(1, 16'd1, 16'h4444, 1, 1, 4'b0001, 1, 16'h0014, 4'b0000, 1, 16'h0001, 1);
    add(0, 0, 0, 0, 0, 4'b0000, 1, 16'h0015, 4'b0000, 1, 16'h0001, 1); // 37
    add(0, 0, 0, 0, 0, 4'b0001, 1, 16'h0010, 4'b0001, 2, 16'h0016, 1); // 38 nest ch0
    add(0, 0, 0, 0, 1, 4'b0100, 1, 16'h0016, 4'b0000, 1, 16'h0001, 1); // 39 iret, ch2 inelig
    add(0, 0, 0, 0, 0, 4'b0000, 1, 16'h0017, 4'b0000, 1, 16'h0001, 1); // 40
    add(0, 0, 0, 0, 0, 4'b0001, 0, 16'h0018, 4'b0000, 1, 16'h0001, 1); // 41 disabled

    rst_n = 1'b0;
    drive_idle();
    #2;
    check("reset", 16'h0000, 4'b0000, 0, 16'h0000, 1'b0);
    @(posedge clk_pc);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; cond = vecs[i].cond; alu = vecs[i].alu;
      pfc_ctrl = vecs[i].pfc; iret = vecs[i].iret; intr = vecs[i].intr;
      intr_en = vecs[i].en;
      @(posedge clk_pc);
      #1;
      check($sformatf("vec%0d", i), vecs[i].x_pc, vecs[i].x_ack, vecs[i].x_nest,
            vecs[i].x_ra, vecs[i].x_err);
    end

    // Asynchronous reset in the middle of a cycle while inside an ISR
    drive_idle();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000, 4'b0000, 0, 16'h0000, 1'b0);
    @(posedge clk_pc);
    #1;
    check("reset_hold", 16'h0000, 4'b0000, 0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    @(posedge clk_pc);
    #1;
    check("after_reset", 16'h0001, 4'b0000, 0, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pfc_vec.md
Name: pfc_vec

Overview:
- Parametrised next-generation program flow controller for the RK16 core.
- Each cycle it selects the next PC: increment, conditional jump to the ALU result, vectored interrupt entry, or return-from-interrupt.
- Supports NINTR prioritised interrupt channels with nesting through a DEPTH-entry return-address/channel stack.
- Sits between the ALU/condition logic and instruction fetch; drives pc, pc_inc and intr_ra.

Parameters:
WIDTH, 16, PC/data width in bits
NINTR, 4, number of interrupt request channels; channel 0 has the highest priority
DEPTH, 4, nesting depth of the return-address stack (at least 1)
RESET_PC, 0, PC value loaded on reset
VEC_BASE, 16'h0010, vector address of channel 0
VEC_STRIDE, 4, address distance between consecutive channel vectors

Ports:
clk_pc  in  1  PC clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
stall  in  1  hold all state this cycle
cond  in  WIDTH  branch condition; a jump is taken when cond != 0
alu  in  WIDTH  jump target
pfc_ctrl  in  1  jump-instruction strobe
iret  in  1  return-from-interrupt strobe
intr  in  NINTR  level-sensitive interrupt requests
intr_en  in  1  global interrupt enable
pc  out  WIDTH  current PC (registered)
pc_inc  out  WIDTH  pc+1 modulo 2^WIDTH (combinational)
intr_ra  out  WIDTH  return address at top of stack; 0 when the stack is empty
intr_ack  out  NINTR  one-hot, one-cycle acknowledge of the channel taken
nest_level  out  $clog2(DEPTH+1)  current stack occupancy
iret_err  out  1  sticky flag, set when iret arrives with an empty stack

Behaviour:
- Reset (async assert, synchronous release on clk_pc): pc=RESET_PC, stack empty, nest_level=0, intr_ra=0, intr_ack=0, iret_err=0.
- Normal next PC (np): alu when (pfc_ctrl && cond!=0), otherwise pc+1. Arithmetic wraps modulo 2^WIDTH.
- Eligible interrupt k: intr[k] && intr_en && k is the lowest asserted index. In addition, either the stack is empty or k < the channel at top of stack. Equal or lower priority never preempts.
- Priority per edge: stall > interrupt take > iret > np.
- stall=1: pc, stack, nest_level and iret_err hold; intr_ack=0.
- Interrupt take (eligible and nest_level<DEPTH):
  - push {np, k};
  - pc <= VEC_BASE + k*VEC_STRIDE (mod 2^WIDTH);
  - intr_ack[k]=1 for exactly the cycle in which pc shows the vector.
- Stack full (nest_level==DEPTH): interrupt is not taken and stays pending; normal flow continues.
- iret without a take, nest_level>0: pop; pc <= popped RA.
- iret without a take, nest_level==0: pc <= pc+1; iret_err <= 1 (cleared only by reset).
- Simultaneous iret and eligible interrupt (tail-chain):
  - eligibility is evaluated against the entry below the top;
  - top entry is replaced with {popped RA, k}; nest_level unchanged;
  - pc <= vector of k; intr_ack[k] pulses.
- Simultaneous iret and ineligible interrupt: plain iret.
- pfc_ctrl during a take: the jump target becomes the pushed RA, not pc.
- No edge detection on intr: a level still asserted after iret is retaken next cycle if eligible.
- Async reset mid-ISR: immediate return to the reset values; the stack is discarded.

Test Plan:
1. Reset with RESET_PC=0, 6 free-running clocks -> pc 0,1,..,6; pc_inc=pc+1. Then pfc_ctrl=1, cond=1, alu=16'h1234 -> pc=16'h1234. Repeat with cond=0 -> pc increments.
2. At pc=5, intr=4'b0100 with intr_en=1 for one clock -> pc=16'h0018, intr_ack=4'b0100 for one cycle, intr_ra=6, nest_level=1. Then iret -> pc=6, nest_level=0.
3. Inside the ch2 ISR: assert intr[3] -> ignored. Assert intr[0] -> pc=16'h0010, nest_level=2, intr_ra=ISR pc+1. Two irets unwind in order.
4. DEPTH=2, both levels filled, higher-priority request held high -> no take, pc increments, intr_ack=0. After one iret the request is taken the next edge.
5. iret at nest_level=0 -> iret_err=1, pc=pc+1; iret_err persists until rst_n pulse. pc=16'hFFFF with no jump -> pc=0 (wrap).
6. iret coinciding with intr[1] at level 1 (ch2 active) -> pc=16'h0014, nest_level stays 1, intr_ra unchanged. stall=1 for 3 cycles -> all outputs frozen. rst_n low mid-ISR -> pc=RESET_PC immediately, nest_level=0.
